// File: rtl/digit_serial_subtractor.sv
// Digit-serial unsigned subtractor: computes minuend - subtrahend - borrow_in one DIGIT-wide
// slice per clock, least-significant digit first, with valid/ready on both sides.
module digit_serial_subtractor #(
    parameter int unsigned parallelism = 32,
    parameter int unsigned DIGIT       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [parallelism-1:0] minuend,
    input  logic [parallelism-1:0] subtrahend,
    input  logic                   borrow_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [parallelism-1:0] diff,
    output logic                   borrow_out
);

    localparam int unsigned N  = parallelism / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastDigit = CW'(N - 1);
    localparam logic [parallelism-1:0] DigitMask = parallelism'({DIGIT{1'b1}});

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [parallelism-1:0] a_q, b_q, diff_q, diff_d;
    logic [CW-1:0]          cnt_q;
    logic                   borrow_q, borrow_out_q;

    logic [31:0]            base;
    logic [parallelism-1:0] a_sh, b_sh;
    logic [DIGIT-1:0]       a_dig, b_dig, d_dig;
    logic                   b_dig_out;
    logic                   accept, last;

    assign accept = (state_q == StIdle) && in_valid;
    assign last   = (cnt_q == LastDigit);

    // Select digit k of both operands and subtract it with the ripple borrow.
    always_comb begin
        base  = 32'(cnt_q) * DIGIT;
        a_sh  = a_q >> base;
        b_sh  = b_q >> base;
        a_dig = a_sh[DIGIT-1:0];
        b_dig = b_sh[DIGIT-1:0];
        // The extra MSB of the DIGIT+1 bit difference is set exactly when the digit underflows.
        {b_dig_out, d_dig} = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_q};
        diff_d = (diff_q & ~(DigitMask << base)) | (parallelism'(d_dig) << base);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                if (last) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Operand capture at accept and per-digit result/borrow update during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else if (accept) begin
            a_q      <= minuend;
            b_q      <= subtrahend;
            borrow_q <= borrow_in;
            cnt_q    <= '0;
        end else if (state_q == StRun) begin
            diff_q   <= diff_d;
            borrow_q <= b_dig_out;
            cnt_q    <= cnt_q + CW'(1);
            if (last) borrow_out_q <= b_dig_out;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench: a 32/8 instance (four digits) and a 16/16 instance (single digit).
module tb_digit_serial_subtractor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  iv, ordy;
    logic [31:0] op_a, op_b;
    logic        op_bin;
    logic        ir0, ov0, bo0, ir1, ov1, bo1;
    logic [31:0] d0;
    logic [15:0] d1;

    int checks   = 0;
    int failures = 0;

    digit_serial_subtractor #(.parallelism(32), .DIGIT(8)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[0]),
        .in_ready   (ir0),
        .minuend    (op_a),
        .subtrahend (op_b),
        .borrow_in  (op_bin),
        .out_valid  (ov0),
        .out_ready  (ordy[0]),
        .diff       (d0),
        .borrow_out (bo0)
    );

    digit_serial_subtractor #(.parallelism(16), .DIGIT(16)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[1]),
        .in_ready   (ir1),
        .minuend    (op_a[15:0]),
        .subtrahend (op_b[15:0]),
        .borrow_in  (op_bin),
        .out_valid  (ov1),
        .out_ready  (ordy[1]),
        .diff       (d1),
        .borrow_out (bo1)
    );

    function automatic logic get_ov(input int sel);
        return (sel != 0) ? ov1 : ov0;
    endfunction

    function automatic logic get_ir(input int sel);
        return (sel != 0) ? ir1 : ir0;
    endfunction

    function automatic logic get_bo(input int sel);
        return (sel != 0) ? bo1 : bo0;
    endfunction

    function automatic logic [31:0] get_diff(input int sel);
        return (sel != 0) ? {16'h0, d1} : d0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One full transaction; returns result and edges from accept to first out_valid.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input bit hold_ready,
                          output logic [31:0] d, output logic bo, output int lat);
        check("in_ready_before_accept", get_ir(sel), 1'b1);
        op_a      = a;
        op_b      = b;
        op_bin    = bin;
        iv[sel]   = 1'b1;
        ordy[sel] = hold_ready;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        // Scramble inputs after accept: they must have no effect.
        op_a   = $urandom;
        op_b   = $urandom;
        op_bin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!get_ov(sel) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = get_diff(sel);
        bo = get_bo(sel);
        check("out_valid_seen", get_ov(sel), 1'b1);
        if (get_ov(sel)) begin
            ordy[sel] = 1'b1;
            @(posedge clk); #1;
            ordy[sel] = 1'b0;
            check("out_valid_drop", get_ov(sel), 1'b0);
            check("in_ready_back", get_ir(sel), 1'b1);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] exp_d;
        logic        exp_bo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        bo;
        int          lat;
        int          hits;

        vecs[0] = '{"small",        32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0};
        vecs[1] = '{"full_borrow",  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[2] = '{"cross_digits", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0};
        vecs[3] = '{"bin_zero",     32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0};
        vecs[4] = '{"max_bin",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{"msb_cross",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0};
        vecs[6] = '{"equal",        32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0};

        // Reset, with in_valid asserted alongside: reset must win.
        rst = 1'b1; iv = 2'b11; ordy = 2'b00; op_a = 32'h5; op_b = 32'h3; op_bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready0", ir0, 1'b1);
        check("rst_out_valid0", ov0, 1'b0);
        check("rst_diff0", d0, 32'h0);
        check("rst_borrow0", bo0, 1'b0);
        check("rst_in_ready1", ir1, 1'b1);
        check("rst_out_valid1", ov1, 1'b0);
        check("rst_diff1", d1, 16'h0);
        rst = 1'b0; iv = 2'b00;
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov0 || ov1) hits++;
        end
        check("no_result_after_rst_with_valid", hits, 0);

        // Directed vectors on the four-digit instance.
        foreach (vecs[i]) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, d, bo, lat);
            check({vecs[i].name, "_diff"}, d, vecs[i].exp_d);
            check({vecs[i].name, "_borrow"}, bo, vecs[i].exp_bo);
            check({vecs[i].name, "_latency"}, lat + 1, 5);
        end

        // Backpressure: result held for 3 cycles, in_valid pulses ignored.
        op_a = 32'h0000_0100; op_b = 32'h0000_0001; op_bin = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_out_valid_seen", ov0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            check("bp_out_valid_held", ov0, 1'b1);
            check("bp_in_ready_low", ir0, 1'b0);
            check("bp_diff_stable", d0, 32'h0000_00FF);
            check("bp_borrow_stable", bo0, 1'b0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("bp_out_valid_drop", ov0, 1'b0);
        check("bp_in_ready_back", ir0, 1'b1);
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov0) hits++;
        end
        check("bp_pulses_not_accepted", hits, 0);
        check("bp_diff_kept_in_idle", d0, 32'h0000_00FF);

        // Reset in the second RUN cycle, then a fresh operation with no stale borrow.
        op_a = 32'h0; op_b = 32'h1; op_bin = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", ir0, 1'b1);
        check("abort_out_valid", ov0, 1'b0);
        check("abort_diff", d0, 32'h0);
        run_op(0, 32'd7, 32'd2, 1'b0, 1'b0, d, bo, lat);
        check("after_abort_diff", d, 32'd5);
        check("after_abort_borrow", bo, 1'b0);

        // Single-digit instance.
        run_op(1, 32'h0000_1234, 32'h0000_1235, 1'b0, 1'b0, d, bo, lat);
        check("n1_diff", d, 32'h0000_FFFF);
        check("n1_borrow", bo, 1'b1);
        check("n1_latency", lat + 1, 2);

        // Random back-to-back stream against (A - B - bin) mod 2^P.
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 30; i++) begin
                logic [31:0] a, b, mask, exp_d;
                logic        bin, exp_bo;
                longint      r;
                mask = (sel != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
                a    = $urandom;
                b    = ((i % 5) == 0) ? a : 32'($urandom);
                bin  = 1'($urandom_range(0, 1));
                r    = longint'(a & mask) - longint'(b & mask) - longint'(bin);
                exp_d  = 32'(r) & mask;
                exp_bo = (r < 0);
                run_op(sel, a, b, bin, sel != 0, d, bo, lat);
                check("rand_diff", d, exp_d);
                check("rand_borrow", bo, exp_bo);
                check("rand_latency", lat + 1, (sel != 0) ? 2 : 5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
